// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the two-digit seven-segment scanner.
// Encodings match the upstream two-digit decoder's segment bus.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        BLANK_H = 2'd0,
        SHOW_H  = 2'd1,
        BLANK_L = 2'd2,
        SHOW_L  = 2'd3
    } state_e;

    localparam logic [1:0] DIG_NONE = 2'b00;
    localparam logic [1:0] DIG_H    = 2'b10;
    localparam logic [1:0] DIG_L    = 2'b01;

    localparam logic [7:0] SEG_ZERO = 8'b0011_1111;

    // Decimal point is ignored so "0." is still treated as a leading zero.
    function automatic logic seg_is_zero(input logic [7:0] seg);
        return seg[6:0] == SEG_ZERO[6:0];
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Time-multiplexed two-digit seven-segment scanner with blanking gaps.
// Define SEG_SCAN_LZ_EN to suppress a leading zero on the tens digit.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int unsigned DWELL = 50000,
    parameter int unsigned BLANK = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] segH,
    input  logic [7:0] segL,
    output logic [7:0] seg_out,
    output logic [1:0] dig_sel,
    output logic       frame_tick
);

    localparam int unsigned CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LOAD_BLANK = CW'(BLANK - 1);
    localparam logic [CW-1:0] LOAD_SHOW  = CW'(DWELL - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      sh_h_q, sh_h_d;
    logic [7:0]      sh_l_q, sh_l_d;
    logic [7:0]      h_pattern;
    logic [7:0]      seg_d;
    logic [1:0]      dig_d;
    logic            tick_d;

    // Next-state, reload and frame capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_h_d  = sh_h_q;
        sh_l_d  = sh_l_q;
        if (!en) begin
            state_d = BLANK_H;
            cnt_d   = LOAD_BLANK;
        end else if (cnt_q == '0) begin
            case (state_q)
                BLANK_H: begin
                    state_d = SHOW_H;
                    cnt_d   = LOAD_SHOW;
                    sh_h_d  = segH;
                    sh_l_d  = segL;
                end
                SHOW_H: begin
                    state_d = BLANK_L;
                    cnt_d   = LOAD_BLANK;
                end
                BLANK_L: begin
                    state_d = SHOW_L;
                    cnt_d   = LOAD_SHOW;
                end
                SHOW_L: begin
                    state_d = BLANK_H;
                    cnt_d   = LOAD_BLANK;
                end
                default: begin
                    state_d = BLANK_H;
                    cnt_d   = LOAD_BLANK;
                end
            endcase
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
`ifdef SEG_SCAN_LZ_EN
        h_pattern = seg_is_zero(sh_h_d) ? 8'h00 : sh_h_d;
`else
        h_pattern = sh_h_d;
`endif
    end

    // Outputs are decoded from the next state so they register on the same edge.
    always_comb begin
        seg_d  = 8'h00;
        dig_d  = DIG_NONE;
        tick_d = 1'b0;
        if (en) begin
            case (state_d)
                SHOW_H: begin
                    seg_d  = h_pattern;
                    dig_d  = DIG_H;
                    tick_d = (state_q == BLANK_H);
                end
                SHOW_L: begin
                    seg_d = sh_l_d;
                    dig_d = DIG_L;
                end
                default: begin
                    seg_d = 8'h00;
                    dig_d = DIG_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BLANK_H;
            cnt_q      <= LOAD_BLANK;
            sh_h_q     <= 8'h00;
            sh_l_q     <= 8'h00;
            seg_out    <= 8'h00;
            dig_sel    <= DIG_NONE;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_h_q     <= sh_h_d;
            sh_l_q     <= sh_l_d;
            seg_out    <= seg_d;
            dig_sel    <= dig_d;
            frame_tick <= tick_d;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan with DWELL=4, BLANK=2.
// Build with SEG_SCAN_LZ_EN defined to check leading-zero suppression.
module tb_seg_scan;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] segH;
    logic [7:0] segL;
    logic [7:0] seg_out;
    logic [1:0] dig_sel;
    logic       frame_tick;

    typedef struct packed {
        logic [7:0] seg;
        logic [1:0] dig;
        logic       tick;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef SEG_SCAN_LZ_EN
    localparam logic [7:0] EXP_3F = 8'h00;
    localparam logic [7:0] EXP_BF = 8'h00;
`else
    localparam logic [7:0] EXP_3F = 8'h3F;
    localparam logic [7:0] EXP_BF = 8'hBF;
`endif

    seg_scan #(
        .DWELL(4),
        .BLANK(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .segH      (segH),
        .segL      (segL),
        .seg_out   (seg_out),
        .dig_sel   (dig_sel),
        .frame_tick(frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop when an expectation is pending.
    always @(negedge clk) begin
        exp_t e;
        check("dig_not_11", {31'b0, dig_sel != 2'b11}, 32'd1);
        if (dig_sel == 2'b00) check("dark_when_unselected", {24'b0, seg_out}, 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("seg_out", {24'b0, seg_out}, {24'b0, e.seg});
            check("dig_sel", {30'b0, dig_sel}, {30'b0, e.dig});
            check("frame_tick", {31'b0, frame_tick}, {31'b0, e.tick});
        end
    end

    task automatic step(input logic [7:0] s, input logic [1:0] d, input logic t);
        exp_t e;
        @(posedge clk);
        #1;
        e.seg  = s;
        e.dig  = d;
        e.tick = t;
        sb.push_back(e);
    endtask

    task automatic blanks(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 2'b00, 1'b0);
    endtask

    task automatic show_h(input logic [7:0] h);
        step(h, 2'b10, 1'b1);
        for (int i = 0; i < 3; i++) step(h, 2'b10, 1'b0);
    endtask

    task automatic show_l(input logic [7:0] l);
        for (int i = 0; i < 4; i++) step(l, 2'b01, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        segH  = 8'h06;
        segL  = 8'h5B;
        #2;
        check("reset_seg", {24'b0, seg_out}, 32'd0);
        check("reset_dig", {30'b0, dig_sel}, 32'd0);
        check("reset_tick", {31'b0, frame_tick}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Startup and two full frames of 06/5B.
        blanks(1);
        show_h(8'h06);
        blanks(2);
        show_l(8'h5B);
        blanks(2);

        // segL change during SHOW_H lands one frame later.
        step(8'h06, 2'b10, 1'b1);
        step(8'h06, 2'b10, 1'b0);
        segL = 8'h4F;
        step(8'h06, 2'b10, 1'b0);
        step(8'h06, 2'b10, 1'b0);
        blanks(2);
        show_l(8'h5B);
        blanks(2);
        show_h(8'h06);
        blanks(2);

        // Drop en for 3 cycles mid-SHOW_L, then a fresh capture.
        step(8'h4F, 2'b01, 1'b0);
        step(8'h4F, 2'b01, 1'b0);
        en   = 1'b0;
        segH = 8'h66;
        segL = 8'h07;
        blanks(3);
        en = 1'b1;
        blanks(1);
        show_h(8'h66);
        blanks(2);
        show_l(8'h07);
        blanks(2);

        // Asynchronous reset mid-SHOW_H.
        step(8'h66, 2'b10, 1'b1);
        step(8'h66, 2'b10, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_seg", {24'b0, seg_out}, 32'd0);
        check("async_rst_dig", {30'b0, dig_sel}, 32'd0);
        check("async_rst_tick", {31'b0, frame_tick}, 32'd0);
        @(posedge clk);
        #1;
        check("held_rst_dig", {30'b0, dig_sel}, 32'd0);
        segH = 8'h3F;
        segL = 8'h6D;
        #1 rst_n = 1'b1;

        // Startup again, with a leading-zero pattern, then 0 with dp.
        blanks(1);
        show_h(EXP_3F);
        blanks(2);
        show_l(8'h6D);
        segH = 8'hBF;
        blanks(2);
        show_h(EXP_BF);
        blanks(2);
        show_l(8'h6D);

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed seven-segment scanner sitting directly downstream of the two-digit decoder. It takes the decoder's two 8-bit segment patterns (tens and ones) and drives them onto a single shared segment bus with a one-hot digit select. A blanking gap between digits prevents ghosting. Both patterns are captured once per frame so a value change never tears across a frame.

## Interface
- `DWELL`, default 50000: cycles each digit is lit; legal range ≥1.
- `BLANK`, default 500: cycles of all-off gap before each digit; legal range ≥1.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  scan enable; low forces display dark.
- `segH`  in  8  tens-digit segment pattern, bit0=a … bit6=g, bit7=dp; active-high.
- `segL`  in  8  ones-digit segment pattern, same encoding.
- `seg_out`  out  8  shared segment bus, active-high.
- `dig_sel`  out  2  digit enable: `2'b10` = tens, `2'b01` = ones, `2'b00` = none.
- `frame_tick`  out  1  one-cycle pulse on entry to SHOW_H.

## Operation
- FSM states, in order: BLANK_H → SHOW_H → BLANK_L → SHOW_L → BLANK_H.
- A single down-counter `cnt` times each state:
  - it is loaded on state entry and the state advances when `cnt` reaches 0;
  - BLANK states last exactly BLANK cycles;
  - SHOW states last exactly DWELL cycles.
- Counter width is `$clog2(max(DWELL,BLANK)+1)`. No wrap is possible: it reloads on every transition.
- Shadow registers `shH` and `shL` capture `segH` and `segL` together on the BLANK_H→SHOW_H edge only. Input changes at any other time take effect at the next frame.
- Outputs are registered and change on the same edge as the state:
  - BLANK_H, BLANK_L: `seg_out` = 0, `dig_sel` = `2'b00`.
  - SHOW_H: `seg_out` = `shH`, `dig_sel` = `2'b10`.
  - SHOW_L: `seg_out` = `shL`, `dig_sel` = `2'b01`.
- `dig_sel` is never `2'b11`. `seg_out` is nonzero only while `dig_sel` is nonzero.
- `en` low, sampled at any edge:
  - next state = BLANK_H with `cnt` = BLANK−1;
  - outputs go dark at that edge and `frame_tick` = 0;
  - this holds every cycle `en` stays low.
- On `en` rising, scanning resumes with a full BLANK_H and a fresh capture.
- Reset, asynchronous and effective mid-frame: state = BLANK_H, `cnt` = BLANK−1, `shH` = `shL` = 0, `seg_out` = 0, `dig_sel` = `2'b00`, `frame_tick` = 0.

## Timing
- Frame period: 2·(DWELL+BLANK) cycles. Tens and ones each get a duty of DWELL/(2·(DWELL+BLANK)).
- Startup: after `rst_n` deasserts with `en` = 1, the first SHOW_H begins at the BLANK-th rising edge.
- Capture-to-display latency: 0 cycles. The pattern captured at an edge is on `seg_out` from that edge.
- Input-change-to-display latency: at most one frame plus 0 cycles.
- `frame_tick` is high for exactly the first cycle of each SHOW_H and coincides with `dig_sel` becoming `2'b10`.
- Transition priority at one edge: reset > `en` low > normal advance.

## Configuration
- Macro: `SEG_SCAN_LZ_EN`, leading-zero suppression.
- Defined: if the captured `shH` equals `SEG_ZERO` (`8'b0011_1111`), SHOW_H drives `seg_out` = 0. `dig_sel` and timing are unchanged, so brightness stays uniform. A decimal point does not defeat suppression: the comparison uses bits[6:0] only.
- Undefined: `shH` is shown verbatim, including a leading 0.

## Structure
- Package `seg_scan_pkg` holds:
  - the state typedef (BLANK_H, SHOW_H, BLANK_L, SHOW_L), 2-bit encoding;
  - `DIG_NONE` = `2'b00`, `DIG_H` = `2'b10`, `DIG_L` = `2'b01`;
  - `SEG_ZERO` = `8'b0011_1111`.
- Single module; counter and FSM are inline. No sub-module: the dwell timer is too small to justify one.

## Test plan
All scenarios use DWELL=4, BLANK=2.
- Reset, then `en` = 1, `segH` = `8'h06`, `segL` = `8'h5B`: `dig_sel` sequence is 00,00,10×4,00×2,01×4, repeating every 12 cycles. `seg_out` = `8'h06` during `2'b10` and `8'h5B` during `2'b01`. `frame_tick` pulses every 12 cycles.
- Change `segL` from `8'h5B` to `8'h4F` during SHOW_H: the current SHOW_L still shows `8'h5B`; the next frame shows `8'h4F`.
- Drop `en` for 3 cycles mid-SHOW_L: outputs are dark at the next edge. After `en` rises: 2 blank cycles, then SHOW_H with a newly captured `segH`.
- Assert `rst_n` = 0 asynchronously mid-SHOW_H: `seg_out` = 0 and `dig_sel` = `2'b00` immediately, before any clock edge. After release, the startup timing matches the first scenario.
- With `SEG_SCAN_LZ_EN` defined and `segH` = `8'h3F`, `segL` = `8'h6D`: SHOW_H has `dig_sel` = `2'b10` and `seg_out` = 0. SHOW_L shows `8'h6D`. Repeat with `segH` = `8'hBF`: still suppressed.
- Throughout every scenario, assert that `dig_sel` ≠ `2'b11` and that `seg_out` = 0 whenever `dig_sel` = `2'b00`.
